actf_pipe: RTL and testbench
============================

ACTF_PIPE -- requirements
Module: actf_pipe

Interface
REQ-001 Parameter WIDTH, default 24, total bits of signed two's-complement input and output samples.
REQ-002 Parameter FRAC, default 20, fractional bits (1.0 = 2^FRAC); WIDTH-FRAC >= 4 SHALL hold.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data/in_mode carry a sample.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  WIDTH  signed Q(WIDTH-FRAC).FRAC operand x.
REQ-008 in_mode  input  1  0 = sigmoid, 1 = tanh; captured with the sample.
REQ-009 out_valid  output  1  out_data holds a result.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  signed Q(WIDTH-FRAC).FRAC result.
REQ-012 out_mode  output  1  mode that produced out_data.

Function
REQ-013 Constants SHALL be floor-scaled: T1=floor(0.8*2^FRAC), T2=floor(3.2*2^FRAC), C4=floor(0.4*2^FRAC), C5=2^(FRAC-1), C6=floor(0.6*2^FRAC), ONE=2^FRAC (FRAC=20: 0x0CCCCC, 0x333333, 0x066666, 0x080000, 0x099999, 0x100000).
REQ-014 Sigmoid s(z) SHALL be: z>T2 -> ONE; z<-T2 -> 0; T1<z<=T2 -> z/8+C6; -T2<=z<-T1 -> z/8+C4; -T1<=z<=T1 -> z/4+C5.
REQ-015 z/4 and z/8 SHALL be arithmetic right shifts (sign-extended, floor rounding).
REQ-016 Mode 0: result = s(x).
REQ-017 Mode 1: z = 2x clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; result = 2*s(z) - ONE, in [-ONE, ONE].
REQ-018 Intermediate sums SHALL use at least WIDTH+1 bits; no wrap-around is permitted in any region.
REQ-019 Pipeline: 3 stages, each with its own valid bit: S1 registers operand (z) and mode; S2 registers region code (sat-hi, sat-lo, outer, inner) and selected slope term/constant; S3 registers final result and mode.
REQ-020 Latency SHALL be exactly 3 cycles from accepted input (in_valid&in_ready) to out_valid with out_ready held high; throughput 1 sample/cycle.
REQ-021 A stage SHALL load when it is empty or its contents advance in the same cycle; in_ready = ~S1.valid | S1 advancing; S3 advances when out_ready.
REQ-022 out_valid = S3.valid; while out_valid & ~out_ready, out_data/out_mode SHALL be held stable.
REQ-023 Bubbles SHALL collapse: an empty stage accepts from the stage behind it even while out_ready is low.
REQ-024 Full condition (all 3 stages valid, out_ready low) SHALL drive in_ready low; no sample lost or duplicated.
REQ-025 Simultaneous accept at input and output in the full state SHALL be allowed (in_ready=1 when out_ready=1).
REQ-026 Samples SHALL emerge in acceptance order; mode per sample is independent (mixed-mode streams allowed).
REQ-027 in_ready may depend combinationally on out_ready; no other input-to-output combinational path.

Reset
REQ-028 rst=1 on a clock edge SHALL clear all valid bits and all data registers; out_valid=0, out_data=0, out_mode=0 the following cycle.
REQ-029 During rst=1 in_ready SHALL be 0; samples in flight at reset are discarded.
REQ-030 First cycle after rst deasserts, in_ready SHALL be 1.

Verification
REQ-031 Sigmoid, out_ready=1, in_data 0x000000/0x100000/0x400000/0xC00000 -> out_data 0x080000/0x0B9999/0x100000/0x000000, each 3 cycles after accept.
REQ-032 Sigmoid boundaries: 0x0CCCCC -> 0x0B3333; 0x0CCCCD -> 0x0B3332; 0x333333 -> 0x0FFFFF; 0x333334 -> 0x100000; 0xF33334 -> 0x04CCCD.
REQ-033 Tanh: 0x000000 -> 0x000000; 0x100000 -> 0x0B3332; 0xC00000 -> 0xF00000; 0x7FFFFF (clamp path) -> 0x100000.
REQ-034 Backpressure: stream 6 samples, out_ready low cycles 2-7 -> in_ready low after 3 accepts, out_data stable while stalled, all 6 results delivered in order, none duplicated.
REQ-035 Random valid/ready toggling, mixed modes, 10k samples vs. reference model -> exact match, order preserved.
REQ-036 rst asserted with 3 samples in flight -> out_valid=0, out_data=0 next cycle; post-reset sample produces correct result with 3-cycle latency.

Source files
------------

// File: rtl/actf_pipe.sv
// Three-stage piecewise-linear sigmoid / tanh unit with valid/ready flow control.
// Stage 1 forms the operand z, stage 2 classifies it, stage 3 sums and rescales.
module actf_pipe #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_mode
);

  localparam int XW = WIDTH + 2;
  typedef logic signed [XW-1:0] wide_t;

  localparam longint ONE_L = longint'(1) << FRAC;
  localparam wide_t  ONE   = wide_t'(ONE_L);
  localparam wide_t  T1    = wide_t'((8 * ONE_L) / 10);
  localparam wide_t  T2    = wide_t'((32 * ONE_L) / 10);
  localparam wide_t  C4    = wide_t'((4 * ONE_L) / 10);
  localparam wide_t  C5    = wide_t'(ONE_L / 2);
  localparam wide_t  C6    = wide_t'((6 * ONE_L) / 10);
  localparam wide_t  ZMAX  = wide_t'((longint'(1) << (WIDTH - 1)) - 1);
  localparam wide_t  ZMIN  = wide_t'(-(longint'(1) << (WIDTH - 1)));

  typedef enum logic [1:0] {
    RG_INNER  = 2'd0,
    RG_OUTER  = 2'd1,
    RG_SAT_HI = 2'd2,
    RG_SAT_LO = 2'd3
  } region_t;

  logic                    v1, v2, v3;
  logic                    m1, m2;
  logic signed [WIDTH-1:0] z1;
  region_t                 rg2;
  wide_t                   term2, cst2;

  logic s1_free, s2_free, s3_free;

  // A stage may load when empty or when its occupant moves on this cycle.
  assign s3_free   = ~v3 | out_ready;
  assign s2_free   = ~v2 | s3_free;
  assign s1_free   = ~v1 | s2_free;
  assign in_ready  = ~rst & s1_free;
  assign out_valid = v3;

  wide_t x_ext, x_dbl, z_next;

  always_comb begin
    x_ext  = wide_t'(in_data);
    x_dbl  = x_ext <<< 1;
    z_next = x_ext;
    if (in_mode) begin
      if (x_dbl > ZMAX)      z_next = ZMAX;
      else if (x_dbl < ZMIN) z_next = ZMIN;
      else                   z_next = x_dbl;
    end
  end

  wide_t   z_ext, term_next, cst_next;
  region_t rg_next;

  always_comb begin
    z_ext     = wide_t'(z1);
    rg_next   = RG_INNER;
    term_next = z_ext >>> 2;
    cst_next  = C5;
    if (z_ext > T2) begin
      rg_next   = RG_SAT_HI;
      term_next = '0;
      cst_next  = '0;
    end else if (z_ext < -T2) begin
      rg_next   = RG_SAT_LO;
      term_next = '0;
      cst_next  = '0;
    end else if (z_ext > T1) begin
      rg_next   = RG_OUTER;
      term_next = z_ext >>> 3;
      cst_next  = C6;
    end else if (z_ext < -T1) begin
      rg_next   = RG_OUTER;
      term_next = z_ext >>> 3;
      cst_next  = C4;
    end
  end

  wide_t s_val, r_val;

  always_comb begin
    case (rg2)
      RG_SAT_HI: s_val = ONE;
      RG_SAT_LO: s_val = '0;
      default:   s_val = term2 + cst2;
    endcase
    r_val = m2 ? (s_val <<< 1) - ONE : s_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      m1       <= 1'b0;
      m2       <= 1'b0;
      z1       <= '0;
      rg2      <= RG_INNER;
      term2    <= '0;
      cst2     <= '0;
      out_data <= '0;
      out_mode <= 1'b0;
    end else begin
      if (s1_free) begin
        v1 <= in_valid;
        if (in_valid) begin
          z1 <= WIDTH'(z_next);
          m1 <= in_mode;
        end
      end
      if (s2_free) begin
        v2 <= v1;
        if (v1) begin
          rg2   <= rg_next;
          term2 <= term_next;
          cst2  <= cst_next;
          m2    <= m1;
        end
      end
      if (s3_free) begin
        v3 <= v2;
        if (v2) begin
          out_data <= WIDTH'(r_val);
          out_mode <= m2;
        end
      end
    end
  end

endmodule

// File: tb/tb_actf_pipe.sv
// Bench for actf_pipe: known-answer table, backpressure, random stream and reset
// scenarios, all checked through an expected-result queue.
module tb_actf_pipe;
  localparam int WIDTH = 24;
  localparam int FRAC  = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid, out_ready, out_mode;
  logic [WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  actf_pipe #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  typedef struct { logic mode; logic [WIDTH-1:0] din; logic [WIDTH-1:0] dout; } vec_t;
  typedef struct { logic [WIDTH-1:0] data; logic mode; logic [WIDTH-1:0] exp; } stim_t;
  typedef struct { logic [WIDTH-1:0] data; logic mode; int cyc; bit lat; } exp_t;

  stim_t            stim[$];
  exp_t             sb[$];
  logic [WIDTH-1:0] cur_exp;
  bit               check_lat;
  int               passed = 0;
  int               total = 0;
  int               cyc = 0;
  int               outs = 0;
  bit               stall_prev = 0;
  logic [WIDTH+1:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q -= 1;
    return q;
  endfunction

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] x, input logic mode);
    longint one, t1, t2, z, s, r, zmax;
    one  = longint'(1) << FRAC;
    t1   = (8 * one) / 10;
    t2   = (32 * one) / 10;
    zmax = (longint'(1) << (WIDTH - 1)) - 1;
    z    = longint'($signed(x));
    if (mode) begin
      z = 2 * z;
      if (z > zmax) z = zmax;
      if (z < -zmax - 1) z = -zmax - 1;
    end
    if (z > t2)       s = one;
    else if (z < -t2) s = 0;
    else if (z > t1)  s = fdiv(z, 8) + (6 * one) / 10;
    else if (z < -t1) s = fdiv(z, 8) + (4 * one) / 10;
    else              s = fdiv(z, 4) + one / 2;
    r = mode ? 2 * s - one : s;
    return WIDTH'(r);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are judged mid-cycle: what is seen here happens at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev)
        check("stall_hold", 32'({out_valid, out_mode, out_data}), 32'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", 32'({out_mode, out_data}), 32'({e.mode, e.data}));
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd3);
          outs++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{data: cur_exp, mode: in_mode, cyc: cyc, lat: check_lat});
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_mode, out_data};
    end
  end

  // rmode 0: ready high, 1: random valid/ready, 2: ready low for the first 6 cycles.
  task automatic run(input int rmode, input int maxcyc);
    int k = 0;
    int accepted = 0;
    bit seen_low = 0;
    check_lat = (rmode == 0);
    while (stim.size() > 0 || sb.size() > 0) begin
      if (k >= maxcyc) begin
        check("timeout", 32'(k), 32'(maxcyc + 1));
        break;
      end
      @(posedge clk); #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k >= 6);
      endcase
      if (stim.size() > 0) begin
        in_valid = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = stim[0].data;
        in_mode  = stim[0].mode;
        cur_exp  = stim[0].exp;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk); #1;
      if (rmode == 2 && !in_ready && !seen_low) begin
        check("full_after_3", 32'(accepted), 32'd3);
        seen_low = 1;
      end
      if (in_valid && in_ready) begin
        void'(stim.pop_front());
        accepted++;
      end
      k++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t tbl[$];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
    cur_exp = '0; check_lat = 0;

    tbl = '{
      '{1'b0, 24'h000000, 24'h080000}, '{1'b0, 24'h100000, 24'h0B9999},
      '{1'b0, 24'h400000, 24'h100000}, '{1'b0, 24'hC00000, 24'h000000},
      '{1'b0, 24'h0CCCCC, 24'h0B3333}, '{1'b0, 24'h0CCCCD, 24'h0B3332},
      '{1'b0, 24'h333333, 24'h0FFFFF}, '{1'b0, 24'h333334, 24'h100000},
      '{1'b0, 24'hF33334, 24'h04CCCD}, '{1'b1, 24'h000000, 24'h000000},
      '{1'b1, 24'h100000, 24'h0B3332}, '{1'b1, 24'hC00000, 24'hF00000},
      '{1'b1, 24'h7FFFFF, 24'h100000}
    };

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'({out_mode, out_data}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < tbl.size(); i++)
      stim.push_back('{data: tbl[i].din, mode: tbl[i].mode, exp: tbl[i].dout});
    run(0, 200);

    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'(32'h0004_0000 * i + 32'hFFF0_0000);
      stim.push_back('{data: d, mode: 1'(i), exp: model(d, 1'(i))});
    end
    outs = 0;
    run(2, 200);
    check("backpressure_count", 32'(outs), 32'd6);

    for (int i = 0; i < 10000; i++) begin
      logic [31:0]      r;
      logic [WIDTH-1:0] d;
      logic             m;
      r = $urandom;
      d = r[31] ? {{2{r[21]}}, r[21:0]} : WIDTH'($urandom);
      m = r[30];
      stim.push_back('{data: d, mode: m, exp: model(d, m)});
    end
    run(1, 60000);

    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(24'h050000 * i); in_mode = 1'b0;
      cur_exp = model(in_data, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("inflight_reset_valid", 32'(out_valid), 32'd0);
    check("inflight_reset_data", 32'({out_mode, out_data}), 32'd0);
    check("inflight_reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("after_reset_in_ready", 32'(in_ready), 32'd1);
    stim.push_back('{data: 24'h100000, mode: 1'b1, exp: 24'h0B3332});
    run(0, 50);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
